// File: rtl/sys_pkg.sv
// Shared definitions for the elevator cab endpoint: floor count and the cab state encoding.
package sys_pkg;

    localparam int NUM_FLOORS = 6;

    typedef enum logic [2:0] {
        PARKED,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPENING,
        DOOR_OPEN,
        DOOR_CLOSING
    } car_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/e_cycle_timer.sv
// Phase timer shared by floor travel and the door sequence; counts up from 0 and flags
// the terminal count so the owner can leave the current phase.
module e_cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         restart,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            count <= '0;
        end else if (count != limit) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == limit);

endmodule

// File: rtl/e_car_unit.sv
// Cab-side endpoint: turns up/down/stop commands into floor travel and a door
// open/dwell/close sequence, reporting location and door state back to the controller.
module e_car_unit #(
    parameter int NUM_FLOORS       = sys_pkg::NUM_FLOORS,
    parameter int LOC_W            = 3,
    parameter int FLOOR_TRAVEL_CYC = 4,
    parameter int DOOR_MOVE_CYC    = 2,
    parameter int DOOR_DWELL_CYC   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic             stop,
    input  logic             door_obstruct,
    output logic [LOC_W-1:0] E_location,
    output logic             door_status,
    output logic             moving,
    output logic             arrived,
    output logic             cmd_err
);

    import sys_pkg::*;

    localparam int TMR_W = $clog2(max3(FLOOR_TRAVEL_CYC, DOOR_MOVE_CYC, DOOR_DWELL_CYC)) + 1;
    localparam logic [LOC_W-1:0] TOP_FLOOR = LOC_W'(NUM_FLOORS - 1);

    car_state_e       state, next_state, dec_state;
    logic [LOC_W-1:0] arrive_loc, dec_floor, next_loc;
    logic             dec_err, next_err, next_arr;
    logic             in_motion, timer_done, timer_restart;
    logic [TMR_W-1:0] timer_limit;

    assign in_motion = (state == MOVE_UP) || (state == MOVE_DOWN);

    // Floor reached at the end of the current travel leg; saturates at the shaft ends.
    always_comb begin
        arrive_loc = E_location;
        if (state == MOVE_UP && E_location != TOP_FLOOR) begin
            arrive_loc = E_location + 1'b1;
        end else if (state == MOVE_DOWN && E_location != '0) begin
            arrive_loc = E_location - 1'b1;
        end
    end

    // Command decode against the floor the car is at (or is arriving at): stop > up > down.
    always_comb begin
        dec_floor = in_motion ? arrive_loc : E_location;
        dec_state = PARKED;
        dec_err   = 1'b0;
        if (stop) begin
            dec_state = DOOR_OPENING;
        end else if (up && down) begin
            dec_err = 1'b1;
        end else if (up) begin
            if (dec_floor == TOP_FLOOR) dec_err = 1'b1;
            else                        dec_state = MOVE_UP;
        end else if (down) begin
            if (dec_floor == '0) dec_err = 1'b1;
            else                 dec_state = MOVE_DOWN;
        end
    end

    always_comb begin
        unique case (state)
            MOVE_UP, MOVE_DOWN:        timer_limit = TMR_W'(FLOOR_TRAVEL_CYC - 1);
            DOOR_OPENING, DOOR_CLOSING: timer_limit = TMR_W'(DOOR_MOVE_CYC - 1);
            DOOR_OPEN:                 timer_limit = TMR_W'(DOOR_DWELL_CYC - 1);
            default:                   timer_limit = '0;
        endcase
    end

    always_comb begin
        next_state = state;
        next_loc   = E_location;
        next_arr   = 1'b0;
        next_err   = 1'b0;
        unique case (state)
            PARKED: begin
                next_state = dec_state;
                next_err   = dec_err;
            end
            MOVE_UP, MOVE_DOWN: begin
                if (timer_done) begin
                    next_loc = arrive_loc;
                    next_arr = 1'b1;
                    next_err = dec_err;
                    // A reversal request parks the car rather than turning it around.
                    if (dec_state == state || dec_state == DOOR_OPENING) next_state = dec_state;
                    else                                                 next_state = PARKED;
                end
            end
            DOOR_OPENING: if (timer_done) next_state = DOOR_OPEN;
            DOOR_OPEN:    if (timer_done && !door_obstruct) next_state = DOOR_CLOSING;
            DOOR_CLOSING: begin
                if (door_obstruct)   next_state = DOOR_OPENING;
                else if (timer_done) next_state = PARKED;
            end
            default: next_state = PARKED;
        endcase
    end

    // The timer restarts on every phase entry, every completed leg, and while an obstruction holds dwell.
    assign timer_restart = (state == PARKED) || timer_done || (next_state != state) ||
                           (state == DOOR_OPEN && door_obstruct);

    e_cycle_timer #(.W(TMR_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (timer_restart),
        .limit   (timer_limit),
        .done    (timer_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PARKED;
            E_location  <= '0;
            door_status <= 1'b1;
            moving      <= 1'b0;
            arrived     <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            state       <= next_state;
            E_location  <= next_loc;
            arrived     <= next_arr;
            cmd_err     <= next_err;
            moving      <= (next_state == MOVE_UP) || (next_state == MOVE_DOWN);
            door_status <= (next_state == PARKED) || (next_state == MOVE_UP) ||
                           (next_state == MOVE_DOWN);
        end
    end

endmodule

// File: tb/tb_e_car_unit.sv
// Scoreboard bench for e_car_unit: a countdown-based cab model predicts output events,
// a separate monitor matches them against what the DUT presents.
module tb_e_car_unit;

    localparam int TRAVEL = 4;
    localparam int DMOVE  = 2;
    localparam int DWELL  = 8;
    localparam int TOP    = 5;

    localparam int IDLE = 0, TRAVELING = 1, OPENING = 2, OPENED = 3, CLOSING = 4;
    localparam int A_NONE = 0, A_DOOR = 1, A_UP = 2, A_DOWN = 3;
    localparam int K_ARR = 0, K_LOC = 1, K_ERR = 2, K_DOOR = 3, K_MOV = 4;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst, up, down, stop, door_obstruct;
    logic [2:0] E_location;
    logic       door_status, moving, arrived, cmd_err;

    ev_t q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    int  m_mode = IDLE, m_loc = 0, m_dir = 0, m_rem = 0, act = 0;
    bit  m_door = 1'b1, m_mov = 1'b0, m_arr, m_err;
    int  prev_loc;
    bit  prev_door, prev_mov;

    int  d_loc = 0;
    bit  d_door = 1'b1, d_mov = 1'b0;

    e_car_unit dut (
        .clk           (clk),
        .rst           (rst),
        .up            (up),
        .down          (down),
        .stop          (stop),
        .door_obstruct (door_obstruct),
        .E_location    (E_location),
        .door_status   (door_status),
        .moving        (moving),
        .arrived       (arrived),
        .cmd_err       (cmd_err)
    );

    always #5 clk = ~clk;

    function automatic string kname(input int k);
        case (k)
            K_ARR:   return "arrived";
            K_LOC:   return "E_location";
            K_ERR:   return "cmd_err";
            K_DOOR:  return "door_status";
            default: return "moving";
        endcase
    endfunction

    task automatic decide(input bit u, input bit d, input bit s, input int floor,
                          output int a, output bit err);
        a   = A_NONE;
        err = 1'b0;
        if (s)                  a = A_DOOR;
        else if (u && d)        err = 1'b1;
        else if (u && floor == TOP) err = 1'b1;
        else if (u)             a = A_UP;
        else if (d && floor == 0) err = 1'b1;
        else if (d)             a = A_DOWN;
    endtask

    task enter(input int a);
        case (a)
            A_DOOR: begin m_mode = OPENING;   m_rem = DMOVE;  end
            A_UP:   begin m_mode = TRAVELING; m_rem = TRAVEL; m_dir = 1;  end
            A_DOWN: begin m_mode = TRAVELING; m_rem = TRAVEL; m_dir = -1; end
            default: m_mode = IDLE;
        endcase
    endtask

    task automatic push(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.cyc  = cyc;
        q.push_back(e);
    endtask

    // Reference model: steps once per clock on the inputs the DUT sees at that edge.
    always @(posedge clk) begin
        cyc++;
        prev_loc  = m_loc;
        prev_door = m_door;
        prev_mov  = m_mov;
        m_arr = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            m_mode = IDLE;
            m_loc  = 0;
            m_rem  = 0;
        end else begin
            case (m_mode)
                IDLE: begin
                    decide(up, down, stop, m_loc, act, m_err);
                    enter(act);
                end
                TRAVELING: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_loc += m_dir;
                        m_arr = 1'b1;
                        decide(up, down, stop, m_loc, act, m_err);
                        if (act == A_DOOR || (act == A_UP && m_dir == 1) ||
                            (act == A_DOWN && m_dir == -1)) enter(act);
                        else m_mode = IDLE;
                    end
                end
                OPENING: begin
                    m_rem--;
                    if (m_rem == 0) begin m_mode = OPENED; m_rem = DWELL; end
                end
                OPENED: begin
                    if (door_obstruct) m_rem = DWELL;
                    else begin
                        m_rem--;
                        if (m_rem == 0) begin m_mode = CLOSING; m_rem = DMOVE; end
                    end
                end
                default: begin
                    if (door_obstruct) begin m_mode = OPENING; m_rem = DMOVE; end
                    else begin
                        m_rem--;
                        if (m_rem == 0) m_mode = IDLE;
                    end
                end
            endcase
        end
        m_door = (m_mode == IDLE) || (m_mode == TRAVELING);
        m_mov  = (m_mode == TRAVELING);
        if (m_arr)              push(K_ARR, 1);
        if (m_loc != prev_loc)  push(K_LOC, m_loc);
        if (m_err)              push(K_ERR, 1);
        if (m_door != prev_door) push(K_DOOR, m_door);
        if (m_mov != prev_mov)  push(K_MOV, m_mov);
    end

    task automatic expectEvent(input int k, input int v);
        checks++;
        if (q.size() == 0 || q[0].cyc != cyc || q[0].kind != k || q[0].val != v) begin
            errors++;
            if (q.size() == 0)
                $display("[TB] FAIL %s cyc=%0d got=%0d required=no event", kname(k), cyc, v);
            else
                $display("[TB] FAIL %s cyc=%0d got=%0d required=%s=%0d at cyc %0d",
                         kname(k), cyc, v, kname(q[0].kind), q[0].val, q[0].cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc && q[0].kind == k) void'(q.pop_front());
    endtask

    // Monitor: reacts only to what the DUT presents, in a fixed per-cycle event order.
    always @(negedge clk) begin
        if (cyc > 0) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL missed_%s cyc=%0d got=no event required=%0d",
                         kname(q[0].kind), q[0].cyc, q[0].val);
                void'(q.pop_front());
            end
            if (arrived === 1'b1)             expectEvent(K_ARR, 1);
            if (int'(E_location) != d_loc)    expectEvent(K_LOC, int'(E_location));
            if (cmd_err === 1'b1)             expectEvent(K_ERR, 1);
            if (door_status !== d_door)       expectEvent(K_DOOR, int'(door_status));
            if (moving !== d_mov)             expectEvent(K_MOV, int'(moving));
            d_loc  = int'(E_location);
            d_door = door_status;
            d_mov  = moving;
        end
    end

    task automatic applyStimulus(input bit u, input bit d, input bit s, input bit o,
                                 input bit r, input int n);
        up            = u;
        down          = d;
        stop          = s;
        door_obstruct = o;
        rst           = r;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    initial begin
        int pu, pd;
        // Reset state
        applyStimulus(0, 0, 0, 0, 1, 2);
        checkOutput("reset_E_location", int'(E_location), 0);
        checkOutput("reset_door_status", int'(door_status), 1);
        checkOutput("reset_moving", int'(moving), 0);
        checkOutput("reset_arrived", int'(arrived), 0);
        checkOutput("reset_cmd_err", int'(cmd_err), 0);
        // Two floors up, stop at the second arrival, full door cycle
        applyStimulus(1, 0, 0, 0, 0, 6);
        applyStimulus(1, 0, 1, 0, 0, 4);
        applyStimulus(0, 0, 0, 0, 0, 16);
        // Top and bottom limits
        applyStimulus(1, 0, 0, 0, 0, 20);
        applyStimulus(0, 0, 0, 0, 0, 2);
        applyStimulus(0, 1, 0, 0, 0, 25);
        applyStimulus(0, 0, 0, 0, 0, 2);
        // Conflicting commands, then up with stop
        applyStimulus(1, 1, 0, 0, 0, 3);
        applyStimulus(1, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 14);
        // Obstruction during the second closing cycle
        applyStimulus(0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 10);
        applyStimulus(0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 16);
        // Reset while moving down past floor 3
        applyStimulus(1, 0, 0, 0, 0, 13);
        applyStimulus(0, 0, 0, 0, 0, 4);
        applyStimulus(0, 1, 0, 0, 0, 6);
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 3);
        // Randomized segments with shifting direction bias
        for (int seg = 0; seg < 60; seg++) begin
            case ($urandom_range(0, 2))
                0:       begin pu = 70; pd = 10; end
                1:       begin pu = 10; pd = 70; end
                default: begin pu = 30; pd = 30; end
            endcase
            for (int i = 0; i < 40; i++) begin
                applyStimulus($urandom_range(0, 99) < pu, $urandom_range(0, 99) < pd,
                              $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 15,
                              $urandom_range(0, 499) == 0, 1);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 24);
        @(negedge clk);
        #1;
        while (q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL leftover_%s cyc=%0d got=no event required=%0d",
                     kname(q[0].kind), q[0].cyc, q[0].val);
            void'(q.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
